// File: rtl/bcd_pkg.sv
// Shared constants for the BCD-to-binary converter: digit geometry,
// reverse double-dabble correction values and FSM state encodings.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int ADJ_THRESH  = 8;
  localparam int ADJ_VAL     = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/bcdtobinary_seq_if.sv
// Handshake and data bundle between the game FSM (master) and the
// BCD-to-binary converter (slave).
interface bcdtobinary_seq_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);

  logic                          start;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in;
  logic [BIN_W-1:0]              binary;
  logic                          done;
  logic                          busy;
  logic                          error;

  modport master (output start, bcd_in, input binary, done, busy, error);
  modport slave  (input start, bcd_in, output binary, done, busy, error);

endinterface

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction step of reverse double dabble: a digit that reads
// 8 or more after the right shift had a borrowed ten and loses 3.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= BCD_DIGIT_W'(ADJ_THRESH)) ? digit - BCD_DIGIT_W'(ADJ_VAL)
                                                        : digit;

endmodule

// File: rtl/bcdtobinary_seq.sv
// Sequential BCD-to-binary converter: one right shift plus digit correction
// per clock over a {bcd, binary} register, with start/busy/done handshake.
module bcdtobinary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
)(
  input  logic              clk,
  input  logic              rst_n,
  bcdtobinary_seq_if.slave  bus
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [1:0]       state;
  logic [SR_W-1:0]  sreg;
  logic [SR_W-1:0]  shifted;
  logic [SR_W-1:0]  next_sreg;
  logic [CNT_W-1:0] cnt;
  logic             err_pend;
  logic             bad_digit;

  assign shifted                = sreg >> 1;
  assign next_sreg[BIN_W-1:0]   = shifted[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (shifted[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (next_sreg[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX))
        bad_digit = 1'b1;
    end
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      err_pend   <= 1'b0;
      bus.binary <= '0;
      bus.done   <= 1'b0;
      bus.error  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sreg      <= {bus.bcd_in, {BIN_W{1'b0}}};
            cnt       <= '0;
            bus.error <= 1'b0;
            err_pend  <= bad_digit;
            state     <= bad_digit ? DONE : CONV;
          end
        end
        CONV: begin
          sreg <= next_sreg;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            bus.binary <= next_sreg[BIN_W-1:0];
            bus.done   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          // An invalid operand spends one cycle here before its done pulse,
          // so the error result lands one cycle after acceptance.
          if (err_pend) begin
            bus.binary <= '0;
            bus.error  <= 1'b1;
            bus.done   <= 1'b1;
            err_pend   <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
